// File: rtl/sp_ram_responder.sv
// Single-port RAM responder with a READ_LATENCY-deep read pipeline and per-access status pulses.
// Define SP_RAM_PARITY_EN to store an even-parity bit per word and report parity_err on reads.
module sp_ram_responder #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
`ifdef SP_RAM_PARITY_EN
    input  logic              err_inject,
    output logic              parity_err,
`endif
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              addr_err
);

`ifdef SP_RAM_PARITY_EN
    localparam int unsigned MEM_W = WIDTH + 1;
`else
    localparam int unsigned MEM_W = WIDTH;
`endif
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam int LAST = int'(READ_LATENCY) - 1;

    logic             in_range;
    logic             wr_fire;
    logic             rd_fire;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;
    logic [MEM_W-1:0] mem [DEPTH];

    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign wr_fire  = cs && we && in_range;
    assign rd_fire  = cs && !we && oe && in_range;

`ifdef SP_RAM_PARITY_EN
    assign wr_word = {(^data_in) ^ err_inject, data_in};
`else
    assign wr_word = data_in;
`endif

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[addr] <= wr_word;
        end
    end

    assign rd_word = mem[addr];

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [MEM_W-1:0]        dat_q [READ_LATENCY];
    logic [MEM_W-1:0]        dat_d [READ_LATENCY];
    logic                    wr_ack_q;
    logic                    addr_err_q;

    always_comb begin
        vld_d[0] = rd_fire;
        dat_d[0] = rd_word;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            wr_ack_q   <= 1'b0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            wr_ack_q   <= wr_fire;
            addr_err_q <= cs && !in_range;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                // The last stage doubles as the data_out holding register.
                if (i != LAST || vld_d[i]) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic parity_err_q;

    // Parity is checked on the word entering the last stage so the flag lines up with rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= vld_d[LAST] && (^dat_d[LAST]);
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign rd_valid = vld_q[LAST];
    assign wr_ack   = wr_ack_q;
    assign addr_err = addr_err_q;
    assign data_out = oe ? dat_q[LAST][WIDTH-1:0] : '0;

endmodule

// File: tb/tb_sp_ram_responder.sv
// Randomized self-checking bench for sp_ram_responder: two instances (DEPTH 16/LAT 1 and
// DEPTH 12/LAT 3) share one input bus and are checked every cycle against a scheduled-event model.
module tb_sp_ram_responder;

    localparam int unsigned DEP_A = 16;
    localparam int unsigned DEP_B = 12;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       oe = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       err_inject = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic       rdv_a, rdv_b, ack_a, ack_b, aerr_a, aerr_b;
`ifdef SP_RAM_PARITY_EN
    logic       perr_a, perr_b;
`endif

    always #5 clk = ~clk;

    sp_ram_responder #(.WIDTH(8), .DEPTH(DEP_A), .ADDR_W(4), .READ_LATENCY(LAT_A)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .we       (we),
        .oe       (oe),
        .addr     (addr),
        .data_in  (data_in),
`ifdef SP_RAM_PARITY_EN
        .err_inject (err_inject),
        .parity_err (perr_a),
`endif
        .data_out (dout_a),
        .rd_valid (rdv_a),
        .wr_ack   (ack_a),
        .addr_err (aerr_a)
    );

    sp_ram_responder #(.WIDTH(8), .DEPTH(DEP_B), .ADDR_W(4), .READ_LATENCY(LAT_B)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .we       (we),
        .oe       (oe),
        .addr     (addr),
        .data_in  (data_in),
`ifdef SP_RAM_PARITY_EN
        .err_inject (err_inject),
        .parity_err (perr_b),
`endif
        .data_out (dout_b),
        .rd_valid (rdv_b),
        .wr_ack   (ack_b),
        .addr_err (aerr_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: array contents per instance plus a table of read results scheduled by due edge.
    int unsigned dep [2] = '{DEP_A, DEP_B};
    int unsigned lat [2] = '{LAT_A, LAT_B};
    logic [7:0]  mem_m  [2][16];
    bit          par_m  [2][16];
    bit          slot_v [2][8];
    logic [7:0]  slot_d [2][8];
    bit          slot_p [2][8];
    logic [7:0]  held   [2];
    bit          exp_ack [2];
    bit          exp_err [2];
    int          cyc = 0;

    function automatic bit inj_eff();
`ifdef SP_RAM_PARITY_EN
        return err_inject;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            held[k] = '0;
            for (int s = 0; s < 8; s++) slot_v[k][s] = 1'b0;
        end
    endtask

    task automatic check_outputs(input int k, input bit rdv, input bit perr);
        string sfx;
        sfx = (k == 0) ? "a" : "b";
        check_eq({"rd_valid_", sfx}, (k == 0) ? rdv_a : rdv_b, rdv);
        check_eq({"data_out_", sfx}, (k == 0) ? dout_a : dout_b, oe ? held[k] : 8'h00);
        check_eq({"wr_ack_", sfx}, (k == 0) ? ack_a : ack_b, exp_ack[k]);
        check_eq({"addr_err_", sfx}, (k == 0) ? aerr_a : aerr_b, exp_err[k]);
`ifdef SP_RAM_PARITY_EN
        check_eq({"parity_err_", sfx}, (k == 0) ? perr_a : perr_b, perr);
`else
        if (perr) check_eq({"parity_model_", sfx}, 32'd1, 32'd0);
`endif
    endtask

    // One clock: apply the access rules to the current inputs, clock, then compare.
    task automatic step();
        int s;
        bit rdv, perr;
        for (int k = 0; k < 2; k++) begin
            exp_ack[k] = 1'b0;
            exp_err[k] = 1'b0;
            if (cs) begin
                if (int'(addr) >= int'(dep[k])) begin
                    exp_err[k] = 1'b1;
                end else if (we) begin
                    mem_m[k][addr] = data_in;
                    par_m[k][addr] = inj_eff();
                    exp_ack[k]     = 1'b1;
                end else if (oe) begin
                    s = (cyc + int'(lat[k]) - 1) % 8;
                    slot_v[k][s] = 1'b1;
                    slot_d[k][s] = mem_m[k][addr];
                    slot_p[k][s] = par_m[k][addr];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            s    = cyc % 8;
            rdv  = slot_v[k][s];
            perr = rdv && slot_p[k][s];
            if (rdv) held[k] = slot_d[k][s];
            slot_v[k][s] = 1'b0;
            check_outputs(k, rdv, perr);
        end
        cyc++;
    endtask

    task automatic access(input bit c, input bit w, input bit o, input logic [3:0] a,
                          input logic [7:0] d, input bit inj);
        cs = c; we = w; oe = o; addr = a; data_in = d; err_inject = inj;
        step();
    endtask

    task automatic idle(input int n);
        cs = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset(input int cycles);
        cs = 1'b0;
        #2;
        rst_n = 1'b0;
        clear_model();
        for (int k = 0; k < 2; k++) begin
            exp_ack[k] = 1'b0;
            exp_err[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k, 1'b0, 1'b0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) check_outputs(k, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        clear_model();
        do_reset(2);

        // Fill: data 3*i+1; instance b flags addresses 12..15.
        for (int i = 0; i < 16; i++) access(1, 1, 1, 4'(i), 8'(3 * i + 1), 0);
        for (int i = 0; i < 16; i++) access(1, 0, 1, 4'(i), 8'h00, 0);
        idle(4);

        // Back-to-back reads.
        access(1, 0, 1, 4'd2, 8'h00, 0);
        access(1, 0, 1, 4'd5, 8'h00, 0);
        access(1, 0, 1, 4'd7, 8'h00, 0);
        idle(4);

        // Out-of-range on b, in range on a; alias address 1 must be untouched.
        access(1, 1, 1, 4'd13, 8'hAA, 0);
        access(1, 0, 1, 4'd13, 8'h00, 0);
        access(1, 0, 0, 4'd13, 8'h00, 0);
        access(1, 0, 1, 4'd1, 8'h00, 0);
        idle(4);

        // Output-enable blanking and hold.
        access(1, 1, 1, 4'd4, 8'h5C, 0);
        access(1, 0, 1, 4'd4, 8'h00, 0);
        idle(3);
        oe = 1'b0;
        idle(2);
        access(1, 0, 0, 4'd4, 8'h00, 0);
        oe = 1'b1;
        idle(4);

        // Parity: injected error then clean word.
        access(1, 1, 1, 4'd3, 8'h0F, 1);
        access(1, 0, 1, 4'd3, 8'h00, 0);
        access(1, 1, 1, 4'd6, 8'h0F, 0);
        access(1, 0, 1, 4'd6, 8'h00, 0);
        idle(4);

        // Reset while a read is in flight on the latency-3 instance.
        access(1, 0, 1, 4'd5, 8'h00, 0);
        idle(1);
        do_reset(2);
        access(1, 0, 1, 4'd5, 8'h00, 0);
        access(1, 0, 1, 4'd2, 8'h00, 0);
        idle(4);

        // Randomized mixed traffic.
        for (int n = 0; n < 400; n++) begin
            access(($urandom % 4) != 0, $urandom % 2, ($urandom % 5) != 0,
                   4'($urandom_range(0, 15)), 8'($urandom), ($urandom % 4) == 0);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
